roll_sweep_engine: RTL

- Row-serial successor to the single-shot combinational removal sweep.
- Accepts a DEPTH x WIDTH occupancy grid over a row-streaming handshake into internal storage, where 1 = roll and 0 = empty.
- Repeats synchronous (Jacobi) removal passes until a pass removes nothing, a pass limit is reached, or single-pass mode ends it.
- Reports total removed and passes executed, and offers registered readback of the final grid.
- Evaluates one row per cycle instead of one full-grid combinational cone.

---
 rtl/roll_sweep_pkg.sv | 20 ++
 rtl/roll_row_eval.sv | 38 +++
 rtl/roll_sweep_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/roll_sweep_pkg.sv
// Shared types and width helpers for the row-serial roll removal sweep engine.
package roll_sweep_pkg;

   typedef enum logic [1:0] {LOAD, ARMED, SWEEP, DONE} state_t;

   localparam int DEFAULT_THRESH = 4;

   function automatic int cnt_w(input int w, input int d);
      return $clog2(w * d + 1);
   endfunction

   function automatic int pass_w(input int w, input int d);
      return $clog2(w * d + 2);
   endfunction

   function automatic int row_cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/roll_row_eval.sv
// Combinational evaluation of one grid row against its pre-pass neighbours:
// produces the surviving row and the number of cells removed from it.
module roll_row_eval import roll_sweep_pkg::*; #(
   parameter int WIDTH  = 16,
   parameter int THRESH = DEFAULT_THRESH,
   localparam int RCW   = row_cnt_w(WIDTH)
) (
   input  logic [WIDTH-1:0] prev_row,
   input  logic [WIDTH-1:0] cur_row,
   input  logic [WIDTH-1:0] next_row,
   output logic [WIDTH-1:0] new_row,
   output logic [RCW-1:0]   row_removed
);

   logic [WIDTH+1:0] p_pad, c_pad, n_pad;
   logic [WIDTH-1:0] removed;

   // zero padding on both sides makes out-of-bounds columns read as empty
   assign p_pad = {1'b0, prev_row, 1'b0};
   assign c_pad = {1'b0, cur_row, 1'b0};
   assign n_pad = {1'b0, next_row, 1'b0};

   for (genvar j = 0; j < WIDTH; j++) begin : g_col
      logic [3:0] nbr;
      assign nbr = 4'(p_pad[j]) + 4'(p_pad[j+1]) + 4'(p_pad[j+2])
                 + 4'(c_pad[j]) + 4'(c_pad[j+2])
                 + 4'(n_pad[j]) + 4'(n_pad[j+1]) + 4'(n_pad[j+2]);
      assign removed[j] = cur_row[j] & (nbr < 4'(THRESH));
   end

   assign new_row = cur_row & ~removed;

   always_comb begin
      row_removed = '0;
      for (int j = 0; j < WIDTH; j++) row_removed += RCW'(removed[j]);
   end

endmodule

// File: rtl/roll_sweep_engine.sv
// Row-serial iterative roll removal engine: streams a grid in, sweeps it one
// row per cycle until stable. Optional pass report ports: ROLL_SWEEP_PASS_REPORT_EN.
//
// state | meaning
// LOAD  | accepting rows 0..DEPTH-1 into the grid
// ARMED | grid loaded, waiting for start
// SWEEP | evaluating/writing back row r of the current pass
// DONE  | results held, readback active, next row starts a reload
module roll_sweep_engine import roll_sweep_pkg::*; #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 16,
   parameter int THRESH     = DEFAULT_THRESH,
   parameter int MAX_PASSES = 0,
   localparam int CNT_W     = cnt_w(WIDTH, DEPTH),
   localparam int PASS_W    = pass_w(WIDTH, DEPTH),
   localparam int IW        = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [WIDTH-1:0]  row_data,
   input  logic              single_pass,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  total_removed,
   output logic [PASS_W-1:0] pass_count,
   input  logic [IW-1:0]     rd_row,
   output logic [WIDTH-1:0]  rd_data
`ifdef ROLL_SWEEP_PASS_REPORT_EN
   ,
   output logic              pass_valid,
   output logic [CNT_W-1:0]  pass_removed
`endif
);

   localparam int RCW = row_cnt_w(WIDTH);

   state_t state, state_nxt;

   logic [WIDTH-1:0] grid [DEPTH];
   logic [IW-1:0]    load_idx, r;
   logic [WIDTH-1:0] prev_q, prev_row, cur_row, next_row, new_row;
   logic [RCW-1:0]   row_removed;
   logic [CNT_W-1:0] pass_acc, pass_sum;
   logic             sp_q, accept, last_row, pass_end, stop;
   logic [IW:0]      rd_ext;

   assign row_ready = (state == LOAD) || (state == DONE);
   assign busy      = (state == SWEEP);
   assign done      = (state == DONE);
   assign accept    = row_valid & row_ready;

   // prev_q holds the pre-write-back copy of row r-1, so every decision sees pre-pass state
   assign last_row  = (r == IW'(DEPTH - 1));
   assign prev_row  = (r == '0) ? '0 : prev_q;
   assign cur_row   = grid[r];
   assign next_row  = last_row ? '0 : grid[r + IW'(1)];
   assign pass_end  = (state == SWEEP) && last_row;
   assign pass_sum  = pass_acc + CNT_W'(row_removed);
   assign stop      = (pass_sum == '0) || sp_q ||
                      ((MAX_PASSES != 0) && (int'(pass_count) + 1 == MAX_PASSES));
   assign rd_ext    = {1'b0, rd_row};

   roll_row_eval #(.WIDTH(WIDTH), .THRESH(THRESH)) u_eval (
      .prev_row    (prev_row),
      .cur_row     (cur_row),
      .next_row    (next_row),
      .new_row     (new_row),
      .row_removed (row_removed)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= LOAD;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:    if (accept && load_idx == IW'(DEPTH - 1)) state_nxt = ARMED;
         ARMED:   if (start) state_nxt = SWEEP;
         SWEEP:   if (pass_end && stop) state_nxt = DONE;
         DONE:    if (accept) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         load_idx      <= '0;
         r             <= '0;
         prev_q        <= '0;
         pass_acc      <= '0;
         sp_q          <= 1'b0;
         total_removed <= '0;
         pass_count    <= '0;
         rd_data       <= '0;
      end else begin
         rd_data <= '0;
         unique case (state)
            LOAD: begin
               if (accept) load_idx <= (load_idx == IW'(DEPTH - 1)) ? '0 : load_idx + IW'(1);
            end
            ARMED: begin
               if (start) begin
                  sp_q     <= single_pass;
                  pass_acc <= '0;
                  r        <= '0;
               end
            end
            SWEEP: begin
               prev_q        <= cur_row;
               total_removed <= total_removed + CNT_W'(row_removed);
               if (last_row) begin
                  pass_count <= pass_count + PASS_W'(1);
                  pass_acc   <= '0;
                  r          <= '0;
               end else begin
                  pass_acc <= pass_sum;
                  r        <= r + IW'(1);
               end
            end
            DONE: begin
               if (rd_ext < (IW+1)'(DEPTH)) rd_data <= grid[rd_row];
               if (accept) begin
                  total_removed <= '0;
                  pass_count    <= '0;
                  load_idx      <= IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // grid storage has no reset; a reset edge simply suppresses the write
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state == SWEEP)  grid[r] <= new_row;
         else if (accept)     grid[(state == DONE) ? '0 : load_idx] <= row_data;
      end
   end

`ifdef ROLL_SWEEP_PASS_REPORT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pass_valid   <= 1'b0;
         pass_removed <= '0;
      end else begin
         pass_valid <= pass_end;
         if (pass_end) pass_removed <= pass_sum;
      end
   end
`endif

endmodule
